hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard unit for the five-stage MIPS pipeline. It combines operand forwarding into D, E and M with Tuse/Tnew stall generation and mult/div busy tracking. The block keeps its own shadow pipeline of producer and consumer tags for the E, M and W slots, so the datapath supplies only D-stage decode information and the raw/forward data buses. It sits beside the D/E/M/W pipeline registers and drives the global stall, which freezes PC and D and inserts a bubble into E.

## Interface
- DATA_W, 32, datapath width
- AW, 5, register address width
- TW, 2, Tuse/Tnew field width
- MULT_CYC, 5, busy cycles after a mult start
- DIV_CYC, 10, busy cycles after a div start
- clk  in  1  clock
- reset  in  1  synchronous, active-high; clears all slots and the busy counter
- flush  in  1  exception/eret; kills the D instruction and the E/M slots
- D_A1, D_A2  in  AW  D-stage source register addresses
- D_A1use, D_A2use  in  1  source actually read
- D_Tuse1, D_Tuse2  in  TW  cycles until the source is needed, measured from D
- D_A3  in  AW  destination register
- D_RegWrite  in  1  D instruction writes D_A3
- D_Tnew  in  TW  Tnew value when the instruction sits in E
- D_md_op  in  2  0 none, 1 mult start, 2 div start, 3 other HI/LO access
- D_RD1, D_RD2, E_RD1, E_RD2, M_WD  in  DATA_W  unforwarded operands
- E_fwd, M_fwd, W_fwd  in  DATA_W  result available in that stage
- D_RD1_FW, D_RD2_FW, E_RD1_FW, E_RD2_FW, M_WD_FW  out  DATA_W  forwarded operands
- stall  out  1  freeze PC/D and bubble E
- md_busy  out  1  busy counter non-zero

## Operation
- Each slot S in {E, M, W} holds A1, A2, A1use, A2use, A3, we and Tnew.
- On reset, every slot clears to all-zero, which is a bubble.
- **Advance on every edge when not in reset:**
  - The W slot loads M's contents. The M slot loads E's contents with Tnew saturating-decremented (0 stays 0).
  - The E slot loads the D fields if neither stall nor flush is active. Otherwise it loads a bubble.
  - The W-slot Tnew is the saturating decrement of M's Tnew.
- **flush:** at the next edge, E, M and W all load bubbles. The instruction currently in W still completes. flush overrides stall.
- **Valid producer P in slot S:** P.we=1, P.A3≠0, and P.A3 equals the consumer address.
- **Forwarding:**
  - A consumer with use=0 passes its raw value through.
  - A consumer address of 0 yields 0.
  - Otherwise the nearest producer with Tnew==0 wins, with the fwd data taken from that stage:
    - D sources check E, then M, then W.
    - E sources check M, then W.
    - M_WD checks W, using the M-slot A2.
  - With no match, the raw value passes through.
- **Stall (combinational):** asserted when any of the following holds:
  - A used D source with a non-zero address matches a producer in E whose Tnew > Tuse.
  - A used D source with a non-zero address matches a producer in M whose Tnew > Tuse.
  - D_md_op≠0 and md_busy=1.
- **Busy counter:**
  - When the D instruction advances into E (no stall, no flush) with D_md_op=1, the counter loads MULT_CYC. With D_md_op=2 it loads DIV_CYC.
  - Otherwise the counter decrements by one if non-zero.
  - flush does not abort a running counter.
  - md_busy = (cnt≠0). The counter width is clog2(max(MULT_CYC, DIV_CYC)+1).

## Timing
- Forward and stall outputs are combinational from the slot state and the D inputs, all within the same cycle.
- Slot state updates one cycle after the D inputs are sampled.
- **Reset values:**
  - stall=0, md_busy=0.
  - Each forwarded output equals its raw input, since all slots are bubbles.
- A load with D_Tnew=2 followed directly by a consumer with Tuse=0: stall for 2 cycles, then forward from W.
- A producer with D_Tnew=1 followed by a consumer with Tuse=0: stall for 1 cycle, then forward M_fwd.
- After a mult start, a following HI/LO instruction stalls for exactly MULT_CYC cycles.

## Test plan
- **ALU chain:** addu $3 (Tnew=1), then addu using $3 as rs with Tuse=1.
  - Expect no stall.
  - Next cycle E_RD1_FW equals M_fwd (0x0000_0007), not the stale E_RD1 value.
- **Load-use:** lw $5 (Tnew=2), then beq reading $5 with Tuse=0.
  - Expect stall high for 2 cycles.
  - Then D_RD1_FW equals W_fwd (0x1234_5678).
- **$0 destination:** a producer with A3=0 and we=1 is followed by a consumer of $0.
  - Expect no stall and a forwarded value of 0, even though the forward buses carry 0xFFFF_FFFF.
- **Mult busy:** mult, then mfhi.
  - Expect md_busy=1 and stall=1 for 5 cycles.
  - mfhi enters E on the 6th cycle.
  - With MULT_CYC=3 the stall lasts 3 cycles.
- **Flush during stall:** a lw/consumer stall with flush asserted in the first stall cycle.
  - Next edge: all slots are bubbles and stall drops to 0.
  - An in-progress div counter keeps counting.
- **Reset mid-operation:** assert reset while a div is busy (cnt=7) and all slots are valid.
  - Next cycle: md_busy=0, stall=0, and every forwarded output equals its raw input.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard unit: operand forwarding into D/E/M, Tuse/Tnew stalls and mult/div busy tracking.
// Latency: forward/stall outputs are combinational; shadow slots advance on every clk edge.
// Backpressure: stall freezes PC/D and bubbles E; flush kills D, E and M on the next edge.
module hazard_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int AW       = 5,
    parameter int TW       = 2,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [AW-1:0]     D_A1,
    input  logic [AW-1:0]     D_A2,
    input  logic              D_A1use,
    input  logic              D_A2use,
    input  logic [TW-1:0]     D_Tuse1,
    input  logic [TW-1:0]     D_Tuse2,
    input  logic [AW-1:0]     D_A3,
    input  logic              D_RegWrite,
    input  logic [TW-1:0]     D_Tnew,
    input  logic [1:0]        D_md_op,
    input  logic [DATA_W-1:0] D_RD1,
    input  logic [DATA_W-1:0] D_RD2,
    input  logic [DATA_W-1:0] E_RD1,
    input  logic [DATA_W-1:0] E_RD2,
    input  logic [DATA_W-1:0] M_WD,
    input  logic [DATA_W-1:0] E_fwd,
    input  logic [DATA_W-1:0] M_fwd,
    input  logic [DATA_W-1:0] W_fwd,
    output logic [DATA_W-1:0] D_RD1_FW,
    output logic [DATA_W-1:0] D_RD2_FW,
    output logic [DATA_W-1:0] E_RD1_FW,
    output logic [DATA_W-1:0] E_RD2_FW,
    output logic [DATA_W-1:0] M_WD_FW,
    output logic              stall,
    output logic              md_busy
);

    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYC);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYC);

    typedef struct packed {
        logic [AW-1:0] a3;
        logic          we;
        logic [TW-1:0] tnew;
    } prod_t;

    typedef struct packed {
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic          a1use;
        logic          a2use;
        prod_t         p;
    } eslot_t;

    // M and W only keep the consumer fields that are still read downstream.
    typedef struct packed {
        logic [AW-1:0] a2;
        logic          a2use;
        prod_t         p;
    } mslot_t;

    localparam eslot_t E_BUBBLE = '0;
    localparam mslot_t M_BUBBLE = '0;
    localparam prod_t  W_BUBBLE = '0;

    eslot_t        e_q;
    mslot_t        m_q;
    prod_t         w_q;
    eslot_t        d_slot;
    logic [CW-1:0] cnt;
    logic          advance;

    function automatic prod_t age(input prod_t p);
        prod_t r;
        r = p;
        r.tnew = (p.tnew == '0) ? '0 : p.tnew - TW'(1);
        return r;
    endfunction

    function automatic logic hit(input prod_t p, input logic [AW-1:0] a);
        return p.we && (p.a3 != '0) && (p.a3 == a);
    endfunction

    function automatic logic ready(input prod_t p, input logic [AW-1:0] a);
        return hit(p, a) && (p.tnew == '0);
    endfunction

    function automatic logic late(input prod_t p, input logic [AW-1:0] a,
                                  input logic rd, input logic [TW-1:0] tuse);
        return rd && (a != '0) && hit(p, a) && (p.tnew > tuse);
    endfunction

    // Candidates are passed nearest-first; the first ready one wins.
    function automatic logic [DATA_W-1:0] pick(
        input logic [AW-1:0] a, input logic rd, input logic [DATA_W-1:0] raw,
        input logic h0, input logic [DATA_W-1:0] d0,
        input logic h1, input logic [DATA_W-1:0] d1,
        input logic h2, input logic [DATA_W-1:0] d2);
        if (!rd)     return raw;
        if (a == '0) return '0;
        if (h0)      return d0;
        if (h1)      return d1;
        if (h2)      return d2;
        return raw;
    endfunction

    assign d_slot = '{a1: D_A1, a2: D_A2, a1use: D_A1use, a2use: D_A2use,
                      p: '{a3: D_A3, we: D_RegWrite, tnew: D_Tnew}};

    assign md_busy = (cnt != '0);

    assign stall = late(e_q.p, D_A1, D_A1use, D_Tuse1)
                 | late(m_q.p, D_A1, D_A1use, D_Tuse1)
                 | late(e_q.p, D_A2, D_A2use, D_Tuse2)
                 | late(m_q.p, D_A2, D_A2use, D_Tuse2)
                 | ((D_md_op != 2'd0) && md_busy);

    assign advance = !stall && !flush;

    assign D_RD1_FW = pick(D_A1, D_A1use, D_RD1,
                           ready(e_q.p, D_A1), E_fwd,
                           ready(m_q.p, D_A1), M_fwd,
                           ready(w_q, D_A1), W_fwd);
    assign D_RD2_FW = pick(D_A2, D_A2use, D_RD2,
                           ready(e_q.p, D_A2), E_fwd,
                           ready(m_q.p, D_A2), M_fwd,
                           ready(w_q, D_A2), W_fwd);
    assign E_RD1_FW = pick(e_q.a1, e_q.a1use, E_RD1,
                           ready(m_q.p, e_q.a1), M_fwd,
                           ready(w_q, e_q.a1), W_fwd,
                           1'b0, '0);
    assign E_RD2_FW = pick(e_q.a2, e_q.a2use, E_RD2,
                           ready(m_q.p, e_q.a2), M_fwd,
                           ready(w_q, e_q.a2), W_fwd,
                           1'b0, '0);
    assign M_WD_FW  = pick(m_q.a2, m_q.a2use, M_WD,
                           ready(w_q, m_q.a2), W_fwd,
                           1'b0, '0, 1'b0, '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= E_BUBBLE;
            m_q <= M_BUBBLE;
            w_q <= W_BUBBLE;
            cnt <= '0;
        end else begin
            w_q <= flush ? W_BUBBLE : age(m_q.p);
            m_q <= flush ? M_BUBBLE : '{a2: e_q.a2, a2use: e_q.a2use, p: age(e_q.p)};
            e_q <= advance ? d_slot : E_BUBBLE;
            // A running mult/div keeps counting through a flush.
            if (advance && (D_md_op == 2'd1)) begin
                cnt <= MULT_LD;
            end else if (advance && (D_md_op == 2'd2)) begin
                cnt <= DIV_LD;
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios then random traffic, checked against
// an instruction-level pipeline model.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic [4:0]  D_A1, D_A2, D_A3;
    logic        D_A1use, D_A2use, D_RegWrite;
    logic [1:0]  D_Tuse1, D_Tuse2, D_Tnew, D_md_op;
    logic [31:0] D_RD1, D_RD2, E_RD1, E_RD2, M_WD, E_fwd, M_fwd, W_fwd;
    wire  [31:0] D_RD1_FW, D_RD2_FW, E_RD1_FW, E_RD2_FW, M_WD_FW;
    wire         stall, md_busy;
    wire  [31:0] s3_d1, s3_d2, s3_e1, s3_e2, s3_m;
    wire         stall3, busy3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset), .flush(flush),
        .D_A1(D_A1), .D_A2(D_A2), .D_A1use(D_A1use), .D_A2use(D_A2use),
        .D_Tuse1(D_Tuse1), .D_Tuse2(D_Tuse2), .D_A3(D_A3), .D_RegWrite(D_RegWrite),
        .D_Tnew(D_Tnew), .D_md_op(D_md_op),
        .D_RD1(D_RD1), .D_RD2(D_RD2), .E_RD1(E_RD1), .E_RD2(E_RD2), .M_WD(M_WD),
        .E_fwd(E_fwd), .M_fwd(M_fwd), .W_fwd(W_fwd),
        .D_RD1_FW(D_RD1_FW), .D_RD2_FW(D_RD2_FW), .E_RD1_FW(E_RD1_FW),
        .E_RD2_FW(E_RD2_FW), .M_WD_FW(M_WD_FW), .stall(stall), .md_busy(md_busy)
    );

    hazard_scoreboard #(.MULT_CYC(3)) dut3 (
        .clk(clk), .reset(reset), .flush(flush),
        .D_A1(D_A1), .D_A2(D_A2), .D_A1use(D_A1use), .D_A2use(D_A2use),
        .D_Tuse1(D_Tuse1), .D_Tuse2(D_Tuse2), .D_A3(D_A3), .D_RegWrite(D_RegWrite),
        .D_Tnew(D_Tnew), .D_md_op(D_md_op),
        .D_RD1(D_RD1), .D_RD2(D_RD2), .E_RD1(E_RD1), .E_RD2(E_RD2), .M_WD(M_WD),
        .E_fwd(E_fwd), .M_fwd(M_fwd), .W_fwd(W_fwd),
        .D_RD1_FW(s3_d1), .D_RD2_FW(s3_d2), .E_RD1_FW(s3_e1),
        .E_RD2_FW(s3_e2), .M_WD_FW(s3_m), .stall(stall3), .md_busy(busy3)
    );

    // Reference model: one record per instruction occupying E (0), M (1), W (2).
    typedef struct {
        int a1, a2, u1, u2, a3, we, tnew;
    } rec_t;

    rec_t pipe[3];
    int   mcnt = 0;

    function automatic rec_t bubble();
        rec_t r;
        r = '{default: 0};
        return r;
    endfunction

    function automatic rec_t aged(rec_t r);
        rec_t o;
        o = r;
        o.tnew = (r.tnew > 0) ? r.tnew - 1 : 0;
        return o;
    endfunction

    function automatic int prod(rec_t r, int a);
        return (r.we != 0 && r.a3 != 0 && r.a3 == a) ? 1 : 0;
    endfunction

    function automatic logic [31:0] fwdbus(int s);
        case (s)
            0:       return E_fwd;
            1:       return M_fwd;
            default: return W_fwd;
        endcase
    endfunction

    function automatic logic [31:0] m_fwd(int a, int u, logic [31:0] raw, int first);
        if (u == 0) return raw;
        if (a == 0) return 32'h0;
        for (int s = first; s < 3; s++)
            if (prod(pipe[s], a) != 0 && pipe[s].tnew == 0) return fwdbus(s);
        return raw;
    endfunction

    function automatic int m_stall();
        int st;
        st = 0;
        for (int s = 0; s < 2; s++) begin
            if (D_A1use && D_A1 != 0 && prod(pipe[s], int'(D_A1)) != 0 && pipe[s].tnew > int'(D_Tuse1)) st = 1;
            if (D_A2use && D_A2 != 0 && prod(pipe[s], int'(D_A2)) != 0 && pipe[s].tnew > int'(D_Tuse2)) st = 1;
        end
        if (D_md_op != 0 && mcnt != 0) st = 1;
        return st;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic rnd_bus();
        D_RD1 = $urandom; D_RD2 = $urandom; E_RD1 = $urandom; E_RD2 = $urandom;
        M_WD  = $urandom; E_fwd = $urandom; M_fwd = $urandom; W_fwd = $urandom;
    endtask

    task automatic set_d(input int a1, input int u1, input int t1, input int a2, input int u2,
                         input int t2, input int a3, input int we, input int tn, input int op);
        D_A1 = 5'(a1); D_A1use = 1'(u1); D_Tuse1 = 2'(t1);
        D_A2 = 5'(a2); D_A2use = 1'(u2); D_Tuse2 = 2'(t2);
        D_A3 = 5'(a3); D_RegWrite = 1'(we); D_Tnew = 2'(tn); D_md_op = 2'(op);
        rnd_bus();
    endtask

    // Checks every output against the model, advances the model, then one clock.
    task automatic cyc(input string tag);
        int   st, adv;
        rec_t nx[3];
        #1;
        st = m_stall();
        chk({tag, "/stall"},   {31'b0, stall},   32'(st));
        chk({tag, "/md_busy"}, {31'b0, md_busy}, (mcnt != 0) ? 32'd1 : 32'd0);
        chk({tag, "/D_RD1_FW"}, D_RD1_FW, m_fwd(int'(D_A1), int'(D_A1use), D_RD1, 0));
        chk({tag, "/D_RD2_FW"}, D_RD2_FW, m_fwd(int'(D_A2), int'(D_A2use), D_RD2, 0));
        chk({tag, "/E_RD1_FW"}, E_RD1_FW, m_fwd(pipe[0].a1, pipe[0].u1, E_RD1, 1));
        chk({tag, "/E_RD2_FW"}, E_RD2_FW, m_fwd(pipe[0].a2, pipe[0].u2, E_RD2, 1));
        chk({tag, "/M_WD_FW"},  M_WD_FW,  m_fwd(pipe[1].a2, pipe[1].u2, M_WD, 2));
        if (reset) begin
            for (int s = 0; s < 3; s++) pipe[s] = bubble();
            mcnt = 0;
        end else begin
            adv   = (st == 0 && !flush) ? 1 : 0;
            nx[2] = flush ? bubble() : aged(pipe[1]);
            nx[1] = flush ? bubble() : aged(pipe[0]);
            nx[0] = adv ? '{int'(D_A1), int'(D_A2), int'(D_A1use), int'(D_A2use),
                            int'(D_A3), int'(D_RegWrite), int'(D_Tnew)} : bubble();
            pipe = nx;
            if (adv != 0 && D_md_op == 2'd1)      mcnt = 5;
            else if (adv != 0 && D_md_op == 2'd2) mcnt = 10;
            else if (mcnt > 0)                    mcnt = mcnt - 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int s3cnt;
        for (int s = 0; s < 3; s++) pipe[s] = bubble();
        reset = 1'b1; flush = 1'b0;
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state: bubbles everywhere, raw values pass through.
        set_d(7, 0, 0, 9, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_busy", {31'b0, md_busy}, 32'd0);
        chk("rst_e1", E_RD1_FW, E_RD1);
        chk("rst_m", M_WD_FW, M_WD);
        cyc("rst");

        // ALU chain: addu $3 then consumer of $3 with Tuse=1.
        set_d(1, 1, 1, 2, 1, 1, 3, 1, 1, 0);
        cyc("alu_p");
        set_d(3, 1, 1, 4, 1, 1, 6, 1, 1, 0);
        #1;
        chk("alu_nostall", {31'b0, stall}, 32'd0);
        cyc("alu_c");
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        M_fwd = 32'h0000_0007;
        E_RD1 = 32'hDEAD_BEEF;
        #1;
        chk("alu_fwd", E_RD1_FW, 32'h0000_0007);
        cyc("alu_e");

        // Load-use: lw $5 (Tnew=2) then beq $5 with Tuse=0.
        set_d(29, 1, 1, 0, 0, 0, 5, 1, 2, 0);
        cyc("lu_p");
        set_d(5, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("lu_stall", {31'b0, stall}, 32'd1);
            cyc("lu_s");
        end
        W_fwd = 32'h1234_5678;
        #1;
        chk("lu_release", {31'b0, stall}, 32'd0);
        chk("lu_fwd", D_RD1_FW, 32'h1234_5678);
        cyc("lu_c");

        // $0 destination never forwards.
        set_d(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc("z_p");
        set_d(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        E_fwd = 32'hFFFF_FFFF; M_fwd = 32'hFFFF_FFFF; W_fwd = 32'hFFFF_FFFF;
        #1;
        chk("z_stall", {31'b0, stall}, 32'd0);
        chk("z_fwd", D_RD1_FW, 32'h0);
        cyc("z_c");
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc("idle");

        // mult then mfhi: 5 stall cycles (3 for the MULT_CYC=3 instance).
        set_d(8, 0, 1, 9, 0, 1, 0, 0, 0, 1);
        cyc("mul");
        set_d(0, 0, 0, 0, 0, 0, 12, 1, 1, 3);
        s3cnt = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (i < 5) begin
                chk("mul_stall", {31'b0, stall}, 32'd1);
                chk("mul_busy", {31'b0, md_busy}, 32'd1);
            end else begin
                chk("mul_release", {31'b0, stall}, 32'd0);
            end
            if (stall3) s3cnt++;
            cyc("mfhi");
        end
        chk("mul3_cycles", 32'(s3cnt), 32'd3);

        // Flush during a load-use stall while a div is running.
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        cyc("div");
        set_d(29, 1, 1, 0, 0, 0, 9, 1, 2, 0);
        cyc("fl_lw");
        set_d(9, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("fl_stall", {31'b0, stall}, 32'd1);
        flush = 1'b1;
        cyc("fl_f");
        flush = 1'b0;
        #1;
        chk("fl_nostall", {31'b0, stall}, 32'd0);
        chk("fl_busy", {31'b0, md_busy}, 32'd1);
        cyc("fl_after");
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (10) cyc("drain");

        // Reset mid-operation: div counter at 7, E/M/W all holding producers.
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        cyc("rdiv");
        for (int i = 0; i < 3; i++) begin
            set_d(1, 1, 1, 2, 1, 1, 10 + i, 1, 1, 0);
            cyc("rprod");
        end
        set_d(10, 1, 3, 11, 1, 3, 0, 0, 0, 0);
        reset = 1'b1;
        cyc("rst_mid");
        reset = 1'b0;
        set_d(12, 0, 0, 11, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rm_busy", {31'b0, md_busy}, 32'd0);
        chk("rm_stall", {31'b0, stall}, 32'd0);
        chk("rm_d1", D_RD1_FW, D_RD1);
        chk("rm_e2", E_RD2_FW, E_RD2);
        cyc("rm");

        // Random traffic on a small register set to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 19) == 0);
            set_d($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0);
            cyc("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
